// File: rtl/fs_serial_sub.sv
// rtl/fs_serial_sub.sv - digit-serial WIDTH-bit subtractor with borrow-in and valid/ready handshakes
module fs_serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bar,
    output logic             zero
);
    localparam int CYCLES = WIDTH / DIGIT;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("fs_serial_sub: DIGIT must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   sub;
    logic             last;

    // One digit of the subtraction; the extra MSB is the outgoing borrow.
    assign sub      = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    assign acc_next = (acc >> DIGIT) | (WIDTH'(sub[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last     = (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial digits accumulate in acc; the visible result only updates on the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bar    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    acc    <= acc_next;
                    borrow <= sub[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff <= acc_next;
                        bar  <= sub[DIGIT];
                        zero <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fs_serial_sub.sv
// tb/tb_fs_serial_sub.sv - directed and swept checks of fs_serial_sub
module tb_fs_serial_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0, diff;
    logic       bin = 1'b0, bar, zero;

    logic         sv_valid = 1'b0, sv_ready = 1'b0, sbin = 1'b0;
    logic [99:0]  sa = '0, sb = '0;
    logic [3:0]   s_ir, s_ov, s_br, s_z;
    logic [7:0]   d81, d88;
    logic [15:0]  d164;
    logic [99:0]  d1005;

    int           errors = 0;
    int           checks = 0;
    int           lat_m;
    int           slat[4];
    logic [127:0] tmp;
    logic [8:0]   e8;
    logic [16:0]  e16;
    logic [100:0] e100;

    always #5 clk = ~clk;

    fs_serial_sub #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bar(bar), .zero(zero));

    fs_serial_sub #(.WIDTH(8), .DIGIT(1)) s81 (
        .clk(clk), .rst(rst), .in_valid(sv_valid), .in_ready(s_ir[0]), .a(sa[7:0]), .b(sb[7:0]), .bin(sbin),
        .out_valid(s_ov[0]), .out_ready(sv_ready), .diff(d81), .bar(s_br[0]), .zero(s_z[0]));
    fs_serial_sub #(.WIDTH(8), .DIGIT(8)) s88 (
        .clk(clk), .rst(rst), .in_valid(sv_valid), .in_ready(s_ir[1]), .a(sa[7:0]), .b(sb[7:0]), .bin(sbin),
        .out_valid(s_ov[1]), .out_ready(sv_ready), .diff(d88), .bar(s_br[1]), .zero(s_z[1]));
    fs_serial_sub #(.WIDTH(16), .DIGIT(4)) s164 (
        .clk(clk), .rst(rst), .in_valid(sv_valid), .in_ready(s_ir[2]), .a(sa[15:0]), .b(sb[15:0]), .bin(sbin),
        .out_valid(s_ov[2]), .out_ready(sv_ready), .diff(d164), .bar(s_br[2]), .zero(s_z[2]));
    fs_serial_sub #(.WIDTH(100), .DIGIT(5)) s1005 (
        .clk(clk), .rst(rst), .in_valid(sv_valid), .in_ready(s_ir[3]), .a(sa), .b(sb), .bin(sbin),
        .out_valid(s_ov[3]), .out_ready(sv_ready), .diff(d1005), .bar(s_br[3]), .zero(s_z[3]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on the main instance and return the cycles until out_valid.
    task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, output int lat);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(tag, 128'({in_ready, out_valid}), 128'(2'b10));
    endtask

    initial begin
        #1;
        chk("reset", 128'({in_ready, out_valid, bar, zero, diff}), 128'({4'b1000, 8'h00}));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        op(8'h5A, 8'h3C, 1'b0, lat_m);
        chk("t1_lat", 128'(lat_m), 128'(4));
        chk("t1_res", 128'({bar, zero, diff}), 128'({2'b00, 8'h1E}));
        drain("t1_drain");

        op(8'h00, 8'h00, 1'b1, lat_m);
        chk("t2a_res", 128'({bar, zero, diff}), 128'({2'b10, 8'hFF}));
        drain("t2a_drain");
        op(8'hFF, 8'hFF, 1'b1, lat_m);
        chk("t2b_res", 128'({bar, zero, diff}), 128'({2'b10, 8'hFF}));
        drain("t2b_drain");
        op(8'h80, 8'h80, 1'b0, lat_m);
        chk("t2c_res", 128'({bar, zero, diff}), 128'({2'b01, 8'h00}));
        drain("t2c_drain");

        op(8'h33, 8'h11, 1'b0, lat_m);
        chk("t3_res", 128'({out_valid, in_ready, bar, zero, diff}), 128'({4'b1000, 8'h22}));
        for (int i = 0; i < 6; i++) begin
            in_valid = ((i % 2) == 0);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            chk("t3_hold", 128'({out_valid, in_ready, bar, zero, diff}), 128'({4'b1000, 8'h22}));
        end
        in_valid = 1'b0;
        drain("t3_release");
        op(8'h07, 8'h09, 1'b0, lat_m);
        chk("t3_next_lat", 128'(lat_m), 128'(4));
        chk("t3_next_res", 128'({bar, zero, diff}), 128'({2'b10, 8'hFE}));
        drain("t3_next_drain");

        a = 8'h10; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t4_async", 128'({out_valid, in_ready, bar, zero, diff}), 128'({4'b0100, 8'h00}));
        @(posedge clk); #1;
        rst = 1'b0;
        op(8'h10, 8'h01, 1'b0, lat_m);
        chk("t4_lat", 128'(lat_m), 128'(4));
        chk("t4_res", 128'({bar, zero, diff}), 128'({2'b00, 8'h0F}));
        drain("t4_drain");

        for (int i = 0; i < 200; i++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom}; sa = tmp[99:0];
            tmp = {$urandom, $urandom, $urandom, $urandom}; sb = tmp[99:0];
            sbin = 1'($urandom);
            if (i == 0) begin sa = '0; sb = '0; sbin = 1'b1; end
            if (i == 1) begin sa = '1; sb = '1; sbin = 1'b1; end
            if (i == 2) begin sa = '1; sb = '0; sbin = 1'b0; end
            if (i == 3) begin sb = sa; sbin = 1'b0; end
            e8   = {1'b0, sa[7:0]} - {1'b0, sb[7:0]} - {8'd0, sbin};
            e16  = {1'b0, sa[15:0]} - {1'b0, sb[15:0]} - {16'd0, sbin};
            e100 = {1'b0, sa} - {1'b0, sb} - {100'd0, sbin};
            sv_valid = 1'b1;
            @(posedge clk); #1;
            sv_valid = 1'b0;
            for (int j = 0; j < 4; j++) slat[j] = 0;
            for (int k = 1; k <= 30; k++) begin
                @(posedge clk); #1;
                for (int j = 0; j < 4; j++) if (s_ov[j] && slat[j] == 0) slat[j] = k;
                if (&s_ov) break;
            end
            chk("sw8_1_lat", 128'(slat[0]), 128'(8));
            chk("sw8_8_lat", 128'(slat[1]), 128'(1));
            chk("sw16_4_lat", 128'(slat[2]), 128'(4));
            chk("sw100_5_lat", 128'(slat[3]), 128'(20));
            chk("sw8_1_res", 128'({s_z[0], s_br[0], d81}), 128'({e8[7:0] == 8'd0, e8}));
            chk("sw8_8_res", 128'({s_z[1], s_br[1], d88}), 128'({e8[7:0] == 8'd0, e8}));
            chk("sw16_4_res", 128'({s_z[2], s_br[2], d164}), 128'({e16[15:0] == 16'd0, e16}));
            chk("sw100_5_res", 128'({s_z[3], s_br[3], d1005}), 128'({e100[99:0] == 100'd0, e100}));
            sv_ready = 1'b1;
            @(posedge clk); #1;
            sv_ready = 1'b0;
            chk("sw_idle", 128'({s_ir, s_ov}), 128'(8'hF0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fs_serial_sub.md
Name: fs_serial_sub

Overview:
Digit-serial N-bit subtractor with borrow-in. It computes diff = a - b - bin and the final borrow over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, carrying the borrow in a register between digits. Operands enter through a valid/ready handshake and the result leaves through a second one. It is the area-reduced, sequential successor to the ripple multi-bit subtractor, for datapaths where WIDTH is large and throughput needs are low.

Parameters:
WIDTH, 8, operand and difference width in bits; must be >= 1.
DIGIT, 2, bits processed per cycle; 1 <= DIGIT <= WIDTH, and WIDTH % DIGIT == 0 is required (elaboration error otherwise).
CYCLES (localparam), WIDTH/DIGIT, number of digit cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand set a/b/bin is valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bar  output  1  borrow-out: 1 iff a < b + bin (unsigned)
zero  output  1  1 iff diff == 0

Behaviour:
- Reset (async assert, release synchronous to clk): state=IDLE, in_ready=1, out_valid=0, diff=0, bar=0, zero=0, digit counter=0, internal operand/borrow registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge, capture a, b into shift registers, set borrow register=bin and cnt=0, then go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, {borrow_next, d} = a_digit - b_digit - borrow, where a_digit and b_digit are the DIGIT LSBs of the shift registers and d is DIGIT bits wide.
    - Shift a and b right by DIGIT bits.
    - Shift d into the diff register from the MSB end, so the first digit lands at bits [DIGIT-1:0] after CYCLES shifts.
    - borrow <= borrow_next; cnt++.
    - On the cycle with cnt==CYCLES-1, go to DONE.
  - DONE: out_valid=1. diff, bar (final borrow) and zero are stable and held. On out_ready, go to IDLE; in_ready becomes 1 the next cycle.
- Latency: out_valid rises exactly CYCLES cycles after the accepting edge. With DIGIT==WIDTH, latency is 1.
- Throughput: at most one operation per CYCLES+2 cycles. No overlap; operands are never accepted in the DONE state.
- in_valid is ignored outside IDLE. a, b and bin need not remain stable after acceptance.
- Backpressure: while out_valid=1 and out_ready=0, all outputs stay bit-stable indefinitely.
- out_ready while out_valid=0 has no effect.
- diff holds its last value in IDLE. zero is registered together with diff and is valid only when out_valid=1.
- Arithmetic is unsigned modular. Borrow chains correctly across digit boundaries, e.g. 0x00 - 0x00 - 1 → 0xFF with bar=1.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. No partial result is ever presented.

Test Plan:
1. WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, bin=0 → diff=0x1E, bar=0, zero=0; out_valid rises exactly 4 cycles after accept.
2. Borrow ripple: a=0x00, b=0x00, bin=1 → diff=0xFF, bar=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bar=1. Then a=0x80, b=0x80, bin=0 → diff=0x00, bar=0, zero=1.
3. Backpressure: hold out_ready=0 for 6 cycles after out_valid, toggling in_valid with new operands → diff/bar/zero/out_valid unchanged and in_ready=0 throughout. Raise out_ready → in_ready=1 on the next cycle and the next operands are accepted.
4. Reset mid-operation: assert rst 2 cycles after accepting a=0x10, b=0x01 → asynchronously out_valid=0, in_ready=1, diff=0. After release, a=0x10, b=0x01, bin=0 → diff=0x0F, bar=0.
5. Parameter sweep: (WIDTH,DIGIT) ∈ {(8,1), (8,8), (16,4), (100,5)}, 200 random operand sets each → diff/bar match {bar,diff} = a - b - bin, and latency == WIDTH/DIGIT.
